// File: rtl/ex_div_pkg.sv
// Shared EX-stage divider definitions: FSM encodings, handshake levels and bus types.
package ex_div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;
  localparam logic        RstEnable         = 1'b1;

  typedef logic [63:0] double_reg_bus_t;

endpackage

// File: rtl/ex_div_step.sv
// One restoring-division step: shift {rem, dividend} left, trial-subtract divisor from the top.
// Purely combinational, no backpressure.
module ex_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  acc_i,
  input  logic [WIDTH-1:0]  divisor_i,
  output logic [2*WIDTH:0]  acc_o
);

  logic [2*WIDTH+1:0] shifted;
  logic [WIDTH+1:0]   diff;

  assign shifted = {acc_i, 1'b0};
  // One guard bit beyond the WIDTH+1 trial window exposes the borrow.
  assign diff    = shifted[2*WIDTH+1:WIDTH] - {2'b00, divisor_i};

  always_comb begin
    if (diff[WIDTH+1]) begin
      acc_o = shifted[2*WIDTH:0];
    end else begin
      acc_o = {diff[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/ex_div.sv
// Radix-2 restoring DIV/DIVU for EX: 33 cycles from start (1 on divide-by-zero); operands latched at start,
// result held while start_i stays high, annul_i/rst abort at the next edge.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CntW = $clog2(WIDTH + 1);

  div_state_e         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               quot_neg_q, quot_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [2*WIDTH:0]   acc_step;
  logic [WIDTH-1:0]   op1_abs, op2_abs;
  logic [WIDTH-1:0]   quot_raw, rem_raw, quot_fix, rem_fix;
  logic               op1_neg, op2_neg;
  logic               start_ok;
  logic               steps_done;

  ex_div_step #(.WIDTH(WIDTH)) u_step (
    .acc_i     (acc_q),
    .divisor_i (divisor_q),
    .acc_o     (acc_step)
  );

  assign op1_neg    = signed_div_i & opdata1_i[WIDTH-1];
  assign op2_neg    = signed_div_i & opdata2_i[WIDTH-1];
  assign op1_abs    = op1_neg ? -opdata1_i : opdata1_i;
  assign op2_abs    = op2_neg ? -opdata2_i : opdata2_i;
  assign start_ok   = (start_i == DivStart) && !annul_i;
  assign steps_done = (cnt_q == CntW'(WIDTH));

  assign quot_raw = acc_q[WIDTH-1:0];
  assign rem_raw  = acc_q[2*WIDTH-1:WIDTH];
  // Remainder follows the dividend's sign; 0x80000000/-1 wraps naturally.
  assign quot_fix = quot_neg_q ? -quot_raw : quot_raw;
  assign rem_fix  = rem_neg_q ? -rem_raw : rem_raw;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= DivFree;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DivFree: begin
        if (start_ok) begin
          state_d = (opdata2_i == '0) ? DivByZero : DivOn;
        end
      end
      DivByZero: state_d = annul_i ? DivFree : DivEnd;
      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
        end else if (steps_done) begin
          state_d = DivEnd;
        end
      end
      DivEnd: begin
        if ((start_i == DivStop) || annul_i) begin
          state_d = DivFree;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    divisor_d  = divisor_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    result_d   = result_q;
    ready_d    = ready_q;
    case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
        if (start_ok) begin
          acc_d      = {{(WIDTH+1){1'b0}}, op1_abs};
          divisor_d  = op2_abs;
          quot_neg_d = op1_neg ^ op2_neg;
          rem_neg_d  = op1_neg;
          cnt_d      = '0;
        end
      end
      DivByZero: begin
        result_d = '0;
        ready_d  = annul_i ? DivResultNotReady : DivResultReady;
      end
      DivOn: begin
        if (annul_i) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
          cnt_d    = '0;
        end else if (!steps_done) begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
        end else begin
          result_d = {rem_fix, quot_fix};
          ready_d  = DivResultReady;
        end
      end
      DivEnd: begin
        if ((start_i == DivStop) || annul_i) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end
      default: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      divisor_q  <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      divisor_q  <= divisor_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: doc/ex_div.md
# ex_div

Multi-cycle radix-2 restoring divider for the EX stage, answering DIV/DIVU operands that the ID/EX register delivers. The EX stage raises a stall request while a division is in flight. The stall controller then freezes the ID/EX register until `ready_o` returns the 64-bit {remainder, quotient} for the HI/LO write. Operands are latched at start, so upstream stalls or flushes never corrupt an operation in progress.

## Interface
- `WIDTH`, 32: operand width; result is 2×WIDTH.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset (`RstEnable`).
- `signed_div_i`  in  1: 1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start_i`.
- `opdata1_i`  in  WIDTH: dividend.
- `opdata2_i`  in  WIDTH: divisor.
- `start_i`  in  1: request; held high by EX until `ready_o` is seen.
- `annul_i`  in  1: abort (exception/flush); highest priority after `rst`.
- `result_o`  out  2×WIDTH: {remainder[63:32], quotient[31:0]}; registered.
- `ready_o`  out  1: result valid; registered.

## Operation
- States: DivFree, DivByZero, DivOn, DivEnd. Reset: state DivFree, `result_o`=0, `ready_o`=0, counter=0, internal registers 0.
- DivFree:
  - If `start_i`=1 and `annul_i`=0, latch the operands and sign mode.
  - Divisor 0 goes to DivByZero. Otherwise go to DivOn with cnt=0.
  - In signed mode, latch absolute values (two's-complement negate when bit 31 is set). Record dividend sign and quotient sign (XOR of signs).
- DivByZero: `result_o`←0, `ready_o`←1, go to DivEnd.
- DivOn with `annul_i`=1: go to DivFree, `ready_o`←0, `result_o`←0, cnt←0.
- DivOn with cnt<32, one restoring step:
  - Shift the {partial remainder, dividend} 65-bit register left by 1.
  - Trial-subtract the divisor from the upper 33 bits (WIDTH+1 unsigned).
  - If non-negative, keep the difference and shift in quotient bit 1; else shift in 0.
  - cnt++.
- DivOn with cnt==32:
  - Negate the quotient if the quotient sign is set (signed mode only).
  - Negate the remainder if the dividend was negative (remainder takes the dividend's sign).
  - Load `result_o`, `ready_o`←1, go to DivEnd.
- DivEnd:
  - Hold `result_o` and `ready_o`=1 while `start_i`=1.
  - When `start_i`=0, go to DivFree with `ready_o`←0 and `result_o`←0.
  - `annul_i` in DivEnd behaves like `start_i`=0.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0 (natural wrap, no trap).
- Unsigned results never negated.

## Timing
- Start sampled at edge N:
  - Normal path: `ready_o` high after edge N+33 (33 DivOn cycles: 32 steps plus sign fix).
  - Divide-by-zero: `ready_o` high after edge N+1.
- `ready_o` and `result_o` change only at clock edges; no combinational path from inputs to outputs.
- Back-to-back operation needs `start_i`=0 for at least one cycle. Earliest next start is sampled at the edge after the return to DivFree.
- `rst` or `annul_i` at any cycle: effective at that edge. No partial result is ever presented.
- `start_i` with `annul_i` in the same DivFree cycle: start ignored.
- Operand changes after the start edge: ignored.

## Structure
- Shared defines file (existing global header) gains:
  - State encodings DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
  - DivResultReady/DivResultNotReady.
  - DivStart/DivStop.
  - Existing `ZeroWord`, `RstEnable`.
  - DoubleRegBus [63:0].
- No mandatory sub-module. A combinational `div_step` (trial subtract + shift, 65-bit in/out) is the natural split if step logic is reused.

## Test plan
- Unsigned 100/7, start at edge N → `ready_o`=1 after N+33, `result_o`=0x00000002_0000000E; holds until `start_i` drops, then 0/0 next edge.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) → `result_o`=0xFFFFFFFF_FFFFFFFD. Signed 7/-2 → 0x00000001_FFFFFFFD.
- Divide by zero, 5/0 → `ready_o`=1 after N+1, `result_o`=0.
- Signed 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000. Unsigned 0xFFFFFFFF/1 → 0x00000000_FFFFFFFF.
- `annul_i` pulse at cnt=10 → DivFree next edge, `ready_o` stays 0. A fresh 9/3 start two cycles later → 0x00000000_00000003 at +33.
- `rst` at cnt=20 → all outputs 0, state DivFree next edge. `start_i`+`annul_i` together in DivFree → no operation begins.
